// File: rtl/control32_pkg.sv
// Shared types and constants for the multi-cycle Minisys control unit.
package control32_pkg;

    // FSM state encoding; values are visible on the debug state output.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALUOp = {R_type|I_format, Branch|nBranch}
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RI     = 2'b10;

    // Instruction class flags from static decode.
    typedef struct packed {
        logic       r_type;
        logic       i_format;
        logic       lw;
        logic       sw;
        logic       jmp;
        logic       jal;
        logic       jr;
        logic       branch;
        logic       nbranch;
        logic       sftmd;
        logic       alusrc;
        logic       regdst;
        logic       legal;
        logic [1:0] alu_op;
    } dec_t;

endpackage

// File: rtl/multicycle_control32_if.sv
// Handshake and access-strobe bundle between the control unit and the memory/IO side.
interface multicycle_control32_if;
    logic ifetch_ready;
    logic mem_ready;
    logic IRWrite;
    logic MemRead;
    logic MemWrite;
    logic IORead;
    logic IOWrite;
    logic bus_error;

    modport master (
        input  ifetch_ready, mem_ready,
        output IRWrite, MemRead, MemWrite, IORead, IOWrite, bus_error
    );

    modport slave (
        output ifetch_ready, mem_ready,
        input  IRWrite, MemRead, MemWrite, IORead, IOWrite, bus_error
    );
endinterface

// File: rtl/control32_decode.sv
// Static instruction decode; same flags as the single-cycle Minisys control unit.
module control32_decode
    import control32_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Pure combinational opcode/funct decode.
    always_comb begin
        dec          = '0;
        dec.r_type   = (opcode == OP_RTYPE);
        dec.i_format = (opcode[5:3] == 3'b001);
        dec.lw       = (opcode == OP_LW);
        dec.sw       = (opcode == OP_SW);
        dec.jmp      = (opcode == OP_J);
        dec.jal      = (opcode == OP_JAL);
        dec.branch   = (opcode == OP_BEQ);
        dec.nbranch  = (opcode == OP_BNE);
        dec.jr       = dec.r_type && (funct == FN_JR);
        dec.sftmd    = dec.r_type && (funct[5:3] == 3'b000);
        dec.alusrc   = dec.i_format | dec.lw | dec.sw;
        dec.regdst   = dec.r_type;
        dec.legal    = dec.r_type | dec.i_format | dec.lw | dec.sw | dec.jmp | dec.jal
                     | dec.branch | dec.nbranch;
        if (dec.r_type || dec.i_format) begin
            dec.alu_op = ALUOP_RI;
        end else if (dec.branch || dec.nbranch) begin
            dec.alu_op = ALUOP_BRANCH;
        end else begin
            dec.alu_op = ALUOP_MEM;
        end
    end

endmodule

// File: rtl/multicycle_control32.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshake, MEM-wait timeout and parametrised IO window decode.
module multicycle_control32
    import control32_pkg::*;
#(
    parameter int unsigned                IO_HIGH_WIDTH = 22,
    parameter logic [IO_HIGH_WIDTH-1:0]   IO_HIGH_MATCH = IO_HIGH_WIDTH'(22'h3FFFFF),
    parameter int unsigned                MEM_TIMEOUT   = 16,
    parameter int unsigned                TCNT_WIDTH    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [5:0]               Opcode,
    input  logic [5:0]               Function_opcode,
    input  logic [IO_HIGH_WIDTH-1:0] ALUResultHigh,
    input  logic                     Zero,
    multicycle_control32_if.master   bus,
    output logic                     RegDST,
    output logic                     ALUSrc,
    output logic                     I_format,
    output logic                     Sftmd,
    output logic                     Jmp,
    output logic                     Jal,
    output logic                     Jr,
    output logic                     Branch,
    output logic                     nBranch,
    output logic [1:0]               ALUOp,
    output logic                     MemOrIOtoReg,
    output logic                     PCWrite,
    output logic                     branch_taken,
    output logic                     RegWrite,
    output logic                     illegal_instr,
    output logic [2:0]               state
);

    localparam bit                    TimeoutEn = (MEM_TIMEOUT != 0);
    localparam logic [TCNT_WIDTH-1:0] TcntLast  =
        TCNT_WIDTH'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t                  state_q;
    logic [TCNT_WIDTH-1:0]   tcnt_q;
    logic                    io_sel_q;
    dec_t                    dec;
    logic                    timeout;
    logic                    ir_write, mem_read, mem_write, io_read, io_write, bus_err;

    control32_decode u_decode (
        .opcode (Opcode),
        .funct  (Function_opcode),
        .dec    (dec)
    );

    assign RegDST       = dec.regdst;
    assign ALUSrc       = dec.alusrc;
    assign I_format     = dec.i_format;
    assign Sftmd        = dec.sftmd;
    assign Jmp          = dec.jmp;
    assign Jal          = dec.jal;
    assign Jr           = dec.jr;
    assign Branch       = dec.branch;
    assign nBranch      = dec.nbranch;
    assign ALUOp        = dec.alu_op;
    assign MemOrIOtoReg = dec.lw;
    assign state        = state_q;

    assign timeout = TimeoutEn && (tcnt_q == TcntLast);

    // State sequencing, MEM wait counter and IO-window select latched on EXEC->MEM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            tcnt_q   <= '0;
            io_sel_q <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.ifetch_ready) state_q <= DECODE;
                end
                DECODE: begin
                    if (dec.jmp || dec.jr)  state_q <= FETCH;
                    else if (dec.jal)       state_q <= WB;
                    else if (dec.legal)     state_q <= EXEC;
                    else                    state_q <= FETCH;
                end
                EXEC: begin
                    if (dec.branch || dec.nbranch) begin
                        state_q <= FETCH;
                    end else if (dec.lw || dec.sw) begin
                        io_sel_q <= (ALUResultHigh == IO_HIGH_MATCH);
                        tcnt_q   <= '0;
                        state_q  <= MEM;
                    end else begin
                        state_q <= WB;
                    end
                end
                MEM: begin
                    // Acknowledge wins over a coincident timeout.
                    if (bus.mem_ready) begin
                        state_q <= dec.lw ? WB : FETCH;
                    end else if (timeout) begin
                        state_q <= FETCH;
                    end else if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                WB:      state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    // State-gated strobes; async reset forces FETCH so all but IRWrite drop with it.
    always_comb begin
        ir_write      = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        branch_taken  = 1'b0;
        illegal_instr = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        io_read       = 1'b0;
        io_write      = 1'b0;
        bus_err       = 1'b0;
        unique case (state_q)
            FETCH: ir_write = bus.ifetch_ready & ~reset;
            DECODE: begin
                if (dec.jmp || dec.jr) begin
                    PCWrite = 1'b1;
                end else if (!dec.legal) begin
                    illegal_instr = 1'b1;
                    PCWrite       = 1'b1;
                end
            end
            EXEC: begin
                if (dec.branch || dec.nbranch) begin
                    PCWrite      = 1'b1;
                    branch_taken = (dec.branch & Zero) | (dec.nbranch & ~Zero);
                end
            end
            MEM: begin
                mem_read  = dec.lw & ~io_sel_q;
                io_read   = dec.lw & io_sel_q;
                mem_write = dec.sw & ~io_sel_q;
                io_write  = dec.sw & io_sel_q;
                if (bus.mem_ready) begin
                    PCWrite = dec.sw;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.IRWrite   = ir_write;
    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.IORead    = io_read;
    assign bus.IOWrite   = io_write;
    assign bus.bus_error = bus_err;

endmodule
